check_node_unit: RTL and testbench



---
 rtl/ldpc_pkg.sv | 28 ++
 rtl/check_node_unit_min2_tracker.sv | 55 +++++
 rtl/check_node_unit.sv | 188 ++++++++++++++++++
 tb/tb_check_node_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: message width, magnitude ceiling,
// check-node FSM states and the saturating absolute-value helper.
package ldpc_pkg;

   localparam int D_WID = 8;
   // Largest representable magnitude of a D_WID-bit two's complement message.
   localparam logic [D_WID-2:0] MAG_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } cnu_state_t;

   // |v|, with the most negative value folded onto MAG_MAX so the result
   // always fits in D_WID-1 bits.
   function automatic logic [D_WID-2:0] sat_abs(input logic [D_WID-1:0] v);
      logic [D_WID-1:0] neg;
      neg = -v;
      if (v == {1'b1, {(D_WID-1){1'b0}}})
         sat_abs = MAG_MAX;
      else if (v[D_WID-1])
         sat_abs = neg[D_WID-2:0];
      else
         sat_abs = v[D_WID-2:0];
   endfunction

endpackage

// File: rtl/check_node_unit_min2_tracker.sv
// cnu_min2_tracker: running smallest / second-smallest magnitude and the
// position of the smallest. The next-state values are exported so the parent
// can build its first output message on the same edge as the last update.
module cnu_min2_tracker
   import ldpc_pkg::*;
#(
   parameter int MAG_WID = D_WID - 1,
   parameter int IDX_WID = 3
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               update,
   input  logic [MAG_WID-1:0] mag,
   input  logic [IDX_WID-1:0] idx,
   output logic [MAG_WID-1:0] min1,
   output logic [MAG_WID-1:0] min2,
   output logic [IDX_WID-1:0] idx1,
   output logic [MAG_WID-1:0] nxt_min1,
   output logic [MAG_WID-1:0] nxt_min2,
   output logic [IDX_WID-1:0] nxt_idx1
);

   // Strict less-than: on a tie the earlier min1 and its index are kept.
   always_comb begin
      nxt_min1 = min1;
      nxt_min2 = min2;
      nxt_idx1 = idx1;
      if (mag < min1) begin
         nxt_min2 = min1;
         nxt_min1 = mag;
         nxt_idx1 = idx;
      end else if (mag < min2) begin
         nxt_min2 = mag;
      end
   end

   // Clear to the magnitude ceiling at row start, otherwise absorb samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min1 <= '1;
         min2 <= '1;
         idx1 <= '0;
      end else if (clear) begin
         min1 <= '1;
         min2 <= '1;
         idx1 <= '0;
      end else if (update) begin
         min1 <= nxt_min1;
         min2 <= nxt_min2;
         idx1 <= nxt_idx1;
      end
   end

endmodule

// File: rtl/check_node_unit.sv
// check_node_unit: serial min-sum check-node processor. Absorbs one row of
// variable-to-check messages, then replays one check-to-variable message per
// row position from min1/min2/idx1 and the sign product.
// Optional build macro: CNU_OFFSET_EN selects offset min-sum (subtract OFFSET,
// floor at zero); undefined gives plain min-sum.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable while valid is high and ready low.
module check_node_unit #(
   parameter int D_WID   = ldpc_pkg::D_WID,
   parameter int MAX_DEG = 8,
   parameter int IDX_WID = 3,
   parameter int OFFSET  = 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [IDX_WID:0]   deg,
   input  logic               vin_valid,
   input  logic [D_WID-1:0]   vin,
   output logic               vin_ready,
   output logic               cout_valid,
   input  logic               cout_ready,
   output logic [D_WID-1:0]   cout,
   output logic [IDX_WID-1:0] cout_idx,
   output logic               parity,
   output logic               done,
   output logic               busy
);
   import ldpc_pkg::*;

   localparam int MAG_WID = D_WID - 1;
   localparam logic [IDX_WID:0] DEG_MIN = (IDX_WID+1)'(2);
   localparam logic [IDX_WID:0] DEG_MAX = (IDX_WID+1)'(MAX_DEG);

`ifdef CNU_OFFSET_EN
   localparam int OFS_AMT = OFFSET;
`else
   // Plain min-sum: the offset contributes nothing.
   localparam int OFS_AMT = 0 * OFFSET;
`endif
   localparam logic [MAG_WID-1:0] OFS = MAG_WID'(OFS_AMT);

   cnu_state_t           state;
   logic [IDX_WID:0]     deg_r;
   logic [IDX_WID:0]     cnt;
   logic [IDX_WID:0]     cnt_inc;
   logic                 cnt_last;
   logic [MAX_DEG-1:0]   sgn_buf;
   logic [MAX_DEG-1:0]   sgn_nxt;
   logic                 s;
   logic                 s_nxt;
   logic [IDX_WID:0]     deg_clamp;
   logic                 hs_in;
   logic                 hs_out;
   logic                 trk_clear;
   logic [MAG_WID-1:0]   mag_in;
   logic [MAG_WID-1:0]   min1, min2, nxt_min1, nxt_min2;
   logic [IDX_WID-1:0]   idx1, nxt_idx1;
   logic [D_WID-1:0]     cout_r;
   logic                 cout_valid_r, parity_r, done_r;

   // Message for position k: the excluded-self minimum, optional offset,
   // then the sign. A zero magnitude negates to zero.
   function automatic logic [D_WID-1:0] make_msg(
      input logic [IDX_WID-1:0] k,
      input logic [IDX_WID-1:0] i1,
      input logic [MAG_WID-1:0] m1,
      input logic [MAG_WID-1:0] m2,
      input logic               sg);
      logic [MAG_WID-1:0] m;
      logic [D_WID-1:0]   ext;
      m   = (k == i1) ? m2 : m1;
      m   = (m > OFS) ? m - OFS : '0;
      ext = {1'b0, m};
      make_msg = sg ? -ext : ext;
   endfunction

   assign mag_in    = sat_abs(vin);
   assign hs_in     = vin_valid && (state == COLLECT);
   assign hs_out    = cout_valid_r && cout_ready;
   assign cnt_inc   = cnt + 1'b1;
   assign cnt_last  = (cnt == deg_r - 1'b1);
   assign s_nxt     = s ^ vin[D_WID-1];
   assign trk_clear = (state == IDLE) && start;

   // Degree clamp into [2, MAX_DEG].
   always_comb begin
      deg_clamp = deg;
      if (deg < DEG_MIN)
         deg_clamp = DEG_MIN;
      else if (deg > DEG_MAX)
         deg_clamp = DEG_MAX;
   end

   // Sign buffer as it will look after the current sample is absorbed.
   always_comb begin
      sgn_nxt = sgn_buf;
      sgn_nxt[cnt[IDX_WID-1:0]] = vin[D_WID-1];
   end

   cnu_min2_tracker #(
      .MAG_WID (MAG_WID),
      .IDX_WID (IDX_WID)
   ) u_min2 (
      .clk      (clk),
      .reset    (reset),
      .clear    (trk_clear),
      .update   (hs_in),
      .mag      (mag_in),
      .idx      (cnt[IDX_WID-1:0]),
      .min1     (min1),
      .min2     (min2),
      .idx1     (idx1),
      .nxt_min1 (nxt_min1),
      .nxt_min2 (nxt_min2),
      .nxt_idx1 (nxt_idx1)
   );

   // Row FSM: collect samples, then emit one registered message per accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         deg_r        <= '0;
         cnt          <= '0;
         sgn_buf      <= '0;
         s            <= 1'b0;
         cout_r       <= '0;
         cout_valid_r <= 1'b0;
         parity_r     <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  deg_r    <= deg_clamp;
                  cnt      <= '0;
                  s        <= 1'b0;
                  sgn_buf  <= '0;
                  parity_r <= 1'b0;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (hs_in) begin
                  sgn_buf <= sgn_nxt;
                  s       <= s_nxt;
                  if (cnt_last) begin
                     cnt          <= '0;
                     parity_r     <= s_nxt;
                     cout_valid_r <= 1'b1;
                     cout_r       <= make_msg('0, nxt_idx1, nxt_min1, nxt_min2,
                                              s_nxt ^ sgn_nxt[0]);
                     state        <= EMIT;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            EMIT: begin
               if (hs_out) begin
                  if (cnt_last) begin
                     cnt          <= '0;
                     cout_valid_r <= 1'b0;
                     cout_r       <= '0;
                     done_r       <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     cnt    <= cnt_inc;
                     cout_r <= make_msg(cnt_inc[IDX_WID-1:0], idx1, min1, min2,
                                        s ^ sgn_buf[cnt_inc[IDX_WID-1:0]]);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign vin_ready  = (state == COLLECT);
   assign busy       = (state != IDLE);
   assign cout_valid = cout_valid_r;
   assign cout       = cout_r;
   assign cout_idx   = cnt[IDX_WID-1:0];
   assign parity     = parity_r;
   assign done       = done_r;

endmodule

// File: tb/tb_check_node_unit.sv
// Self-checking bench for check_node_unit (D_WID=8, MAX_DEG=8).
// Expected messages come from a row-level min-sum model; CNU_OFFSET_EN in the
// build switches the model to offset min-sum with offset 1.
module tb_check_node_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] deg;
   logic       vin_valid;
   logic [7:0] vin;
   logic       vin_ready;
   logic       cout_valid;
   logic       cout_ready;
   logic [7:0] cout;
   logic [2:0] cout_idx;
   logic       parity;
   logic       done;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   logic [7:0] vin_arr[16];
   logic       exp_parity;

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   check_node_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .deg        (deg),
      .vin_valid  (vin_valid),
      .vin        (vin),
      .vin_ready  (vin_ready),
      .cout_valid (cout_valid),
      .cout_ready (cout_ready),
      .cout       (cout),
      .cout_idx   (cout_idx),
      .parity     (parity),
      .done       (done),
      .busy       (busy)
   );

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp_deg(input int d);
      if (d < 2) return 2;
      if (d > 8) return 8;
      return d;
   endfunction

   // Row model: for each position, the smallest magnitude among the other
   // positions and the product of the other positions' signs.
   task automatic build_expect(input int dd);
      int mags[16];
      bit sg[16];
      int v, m1, i1, m2, mag, val;
      bit par, sign;
      par = 1'b0;
      for (int k = 0; k < dd; k++) begin
         v = int'($signed(vin_arr[k]));
         if (v == -128) mags[k] = 127;
         else if (v < 0) mags[k] = -v;
         else mags[k] = v;
         sg[k] = (v < 0);
         par ^= sg[k];
      end
      m1 = 127; i1 = 0;
      for (int k = 0; k < dd; k++)
         if (mags[k] < m1) begin m1 = mags[k]; i1 = k; end
      m2 = 127;
      for (int k = 0; k < dd; k++)
         if (k != i1 && mags[k] < m2) m2 = mags[k];
      exp_q.delete();
      for (int k = 0; k < dd; k++) begin
         mag = (k == i1) ? m2 : m1;
`ifdef CNU_OFFSET_EN
         mag = (mag > 1) ? mag - 1 : 0;
`endif
         sign = par ^ sg[k];
         val = sign ? -mag : mag;
         exp_q.push_back(8'(val));
      end
      exp_parity = par;
   endtask

   task automatic set_row(input int a, input int b, input int c, input int d);
      vin_arr[0] = 8'(a);
      vin_arr[1] = 8'(b);
      vin_arr[2] = 8'(c);
      vin_arr[3] = 8'(d);
   endtask

   // Driver: one full row. stall_mode 0 = always ready, 1 = random ready,
   // 2 = hold ready low for stall_len cycles at position stall_at.
   task automatic run_row(input int d_in, input int gap_max, input int stall_mode,
                          input int stall_at, input int stall_len, input int exp_cycles);
      int dd, c0, k, budget, stalled, g;
      logic r;
      logic [7:0] e;
      dd = clamp_deg(d_in);
      build_expect(dd);
      start = 1'b1;
      deg = 4'(d_in);
      c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk_val("busy_after_start", 32'(busy), 32'd1);
      chk_val("ready_after_start", 32'(vin_ready), 32'd1);
      for (int i = 0; i < dd; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (g) @(negedge clk);
         vin_valid = 1'b1;
         vin = vin_arr[i];
         budget = 0;
         while (!vin_ready && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 50) chk_val("vin_ready_timeout", 32'd0, 32'd1);
         @(negedge clk);
         vin_valid = 1'b0;
         vin = 8'($urandom);
      end
      chk_val("valid_enter_emit", 32'(cout_valid), 32'd1);
      chk_val("idx_enter_emit", 32'(cout_idx), 32'd0);
      chk_val("parity", 32'(parity), 32'(exp_parity));
      k = 0; budget = 0; stalled = 0;
      while (k < dd && budget < 200) begin
         e = exp_q[0];
         chk_val("cout_valid", 32'(cout_valid), 32'd1);
         chk_val("cout_idx", 32'(cout_idx), 32'(k));
         chk_val("cout", 32'(cout), 32'(e));
         chk_val("no_early_done", 32'(done), 32'd0);
         if (stall_mode == 1)
            r = ($urandom_range(0, 3) != 0);
         else if (stall_mode == 2 && k == stall_at && stalled < stall_len) begin
            r = 1'b0;
            stalled++;
         end else
            r = 1'b1;
         cout_ready = r;
         @(negedge clk);
         budget++;
         if (r) begin
            void'(exp_q.pop_front());
            k++;
         end
      end
      if (budget >= 200) chk_val("emit_timeout", 32'd0, 32'd1);
      cout_ready = 1'b1;
      chk_val("done_pulse", 32'(done), 32'd1);
      chk_val("idle_after_row", 32'(busy), 32'd0);
      chk_val("valid_after_row", 32'(cout_valid), 32'd0);
      chk_val("parity_hold", 32'(parity), 32'(exp_parity));
      if (exp_cycles >= 0) chk_val("row_cycles", 32'(cyc - c0), 32'(exp_cycles));
      @(negedge clk);
      chk_val("done_one_cycle", 32'(done), 32'd0);
   endtask

   // Main sequence
   initial begin
      int d, tmp, sel;
      reset = 1'b1; start = 1'b0; deg = '0;
      vin_valid = 1'b0; vin = '0; cout_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_val("rst_vin_ready", 32'(vin_ready), 32'd0);
      chk_val("rst_cout_valid", 32'(cout_valid), 32'd0);
      chk_val("rst_cout", 32'(cout), 32'd0);
      chk_val("rst_cout_idx", 32'(cout_idx), 32'd0);
      chk_val("rst_parity", 32'(parity), 32'd0);
      chk_val("rst_done", 32'(done), 32'd0);
      chk_val("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Valid outside COLLECT is ignored.
      vin_valid = 1'b1; vin = 8'h80;
      @(negedge clk);
      vin_valid = 1'b0;
      chk_val("idle_ignores_vin", 32'(busy), 32'd0);

      set_row(5, -3, 7, -9);
      run_row(4, 0, 0, 0, 0, 9);
      set_row(-128, 10, 0, 0);
      run_row(2, 0, 0, 0, 0, 5);
      set_row(4, -4, 6, 0);
      run_row(3, 0, 0, 0, 0, 7);
      set_row(5, -3, 7, -9);
      run_row(4, 0, 2, 1, 3, 12);
      set_row(0, -1, 1, 0);
      run_row(4, 0, 0, 0, 0, 9);

      // Abort mid-row with reset.
      set_row(5, -3, 7, -9);
      start = 1'b1; deg = 4'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vin_valid = 1'b1; vin = vin_arr[i];
         @(negedge clk);
      end
      vin_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk_val("abort_busy", 32'(busy), 32'd0);
      chk_val("abort_ready", 32'(vin_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk_val("abort_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      run_row(4, 0, 0, 0, 0, 9);

      // Randomized rows including out-of-range degrees and extreme values.
      for (int row = 0; row < 40; row++) begin
         d = int'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 7));
            tmp = int'($urandom_range(0, 16));
            if (sel == 0) vin_arr[i] = 8'h80;
            else if (sel == 1) vin_arr[i] = 8'h00;
            else if (sel < 5) vin_arr[i] = 8'(tmp - 8);
            else vin_arr[i] = 8'($urandom);
         end
         run_row(d, 2, 1, 0, 0, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
